// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/wb sequencing
// with memory handshake, branch resolution and retire counting.
module mc_control_fsm #(
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         instr,
  input  logic                mem_ready,
  input  logic                zero,
  output logic [1:0]          ALUOp,
  output logic [3:0]          Opcode,
  output logic                ir_load,
  output logic                pc_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                alu_src,
  output logic                reg_dst,
  output logic [1:0]          pc_src,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t              r_state;
  logic [3:0]          r_opc;
  logic [RETIRE_W-1:0] r_ret;

  logic w_ld;
  logic w_st;
  logic w_br;
  logic w_bne;
  logic w_jmp;
  logic w_ill;
  logic w_rtype;

  assign w_ld    = (r_opc == 4'b0000);
  assign w_st    = (r_opc == 4'b0001);
  assign w_bne   = (r_opc == 4'b1100);
  assign w_br    = (r_opc == 4'b1011) || w_bne;
  assign w_jmp   = (r_opc == 4'b1101);
  assign w_ill   = (r_opc == 4'b1010) || (r_opc >= 4'b1110);
  assign w_rtype = (r_opc >= 4'b0010) && (r_opc <= 4'b1001);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_opc   <= 4'b0000;
      r_ret   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          if (mem_ready) begin
            r_opc   <= instr[15:12];
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_jmp) begin
            r_ret   <= r_ret + RETIRE_W'(1);
            r_state <= S_FETCH;
          end else if (w_ill) begin
            r_state <= S_FETCH;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_ld || w_st) begin
            r_state <= S_MEM;
          end else if (w_rtype) begin
            r_state <= S_WB;
          end else begin
            if (w_br) r_ret <= r_ret + RETIRE_W'(1);
            r_state <= S_FETCH;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (w_ld) begin
              r_state <= S_WB;
            end else begin
              r_ret   <= r_ret + RETIRE_W'(1);
              r_state <= S_FETCH;
            end
          end
        end
        S_WB: begin
          r_ret   <= r_ret + RETIRE_W'(1);
          r_state <= S_FETCH;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode from registered state/opcode; only FETCH, MEM
  // and branch EXEC look at the handshake and flag inputs.
  always_comb begin
    ALUOp      = 2'b00;
    ir_load    = 1'b0;
    pc_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    pc_src     = 2'b00;
    illegal    = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_load  = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: begin
        if (w_jmp) begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
        illegal = w_ill;
      end
      S_EXEC: begin
        if (w_ld || w_st) begin
          ALUOp   = 2'b10;
          alu_src = 1'b1;
        end else if (w_br) begin
          ALUOp    = 2'b01;
          pc_src   = 2'b01;
          pc_write = w_bne ? ~zero : zero;
        end
      end
      S_MEM: begin
        mem_read  = w_ld;
        mem_write = w_st;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = w_ld;
        reg_dst    = w_rtype;
      end
      default: ;
    endcase
  end

  assign Opcode  = r_opc;
  assign retired = r_ret;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm; per-cycle expected strobes
// go through a scoreboard queue and are checked before each edge.
module tb_mc_control_fsm;

  typedef struct packed {
    logic [1:0] aluop;
    logic [3:0] opc;
    logic       ir;
    logic       pcw;
    logic       mr;
    logic       mw;
    logic       rw;
    logic       m2r;
    logic       as;
    logic       rd;
    logic [1:0] pcs;
    logic       ill;
  } out_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = 16'h0000;
  logic        mem_ready = 1'b0;
  logic        zero = 1'b0;

  logic [1:0]  aluop, aluop_w;
  logic [3:0]  opc, opc_w;
  logic        ir, pcw, mr, mw, rw, m2r, as, rd, ill;
  logic        ir_w, pcw_w, mr_w, mw_w, rw_w, m2r_w, as_w, rd_w, ill_w;
  logic [1:0]  pcs, pcs_w;
  logic [15:0] ret;
  logic [2:0]  ret_w;

  out_t obs, obs_w;
  out_t q_out[$];
  int   q_ret[$];
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk), .rst(rst), .instr(instr),
    .mem_ready(mem_ready), .zero(zero),
    .ALUOp(aluop), .Opcode(opc), .ir_load(ir),
    .pc_write(pcw), .mem_read(mr), .mem_write(mw),
    .reg_write(rw), .mem_to_reg(m2r), .alu_src(as),
    .reg_dst(rd), .pc_src(pcs), .illegal(ill),
    .retired(ret)
  );

  mc_control_fsm #(.RETIRE_W(3)) dut_w (
    .clk(clk), .rst(rst), .instr(instr),
    .mem_ready(mem_ready), .zero(zero),
    .ALUOp(aluop_w), .Opcode(opc_w), .ir_load(ir_w),
    .pc_write(pcw_w), .mem_read(mr_w), .mem_write(mw_w),
    .reg_write(rw_w), .mem_to_reg(m2r_w), .alu_src(as_w),
    .reg_dst(rd_w), .pc_src(pcs_w), .illegal(ill_w),
    .retired(ret_w)
  );

  assign obs   = {aluop, opc, ir, pcw, mr, mw, rw, m2r,
                  as, rd, pcs, ill};
  assign obs_w = {aluop_w, opc_w, ir_w, pcw_w, mr_w, mw_w,
                  rw_w, m2r_w, as_w, rd_w, pcs_w, ill_w};

  function automatic out_t mk(
    input logic [1:0] a, input logic [3:0] o,
    input logic i, input logic pw, input logic r,
    input logic w, input logic g, input logic m,
    input logic s, input logic d, input logic [1:0] p,
    input logic l);
    mk = {a, o, i, pw, r, w, g, m, s, d, p, l};
  endfunction

  task automatic chk(input string tag);
    out_t e;
    int   er;
    logic [2:0] er_w;
    if (q_out.size() == 0) begin
      n_total++;
      $error("FAIL %s scoreboard empty", tag);
      return;
    end
    e  = q_out.pop_front();
    er = q_ret.pop_front();
    er_w = 3'(er);
    n_total++;
    assert (obs === e) n_pass++;
    else $error("FAIL %s outputs got %h exp %h", tag, obs, e);
    n_total++;
    assert (obs_w === e) n_pass++;
    else $error("FAIL %s w-outputs got %h exp %h",
                tag, obs_w, e);
    n_total++;
    assert (ret === 16'(er)) n_pass++;
    else $error("FAIL %s retired got %0d exp %0d",
                tag, ret, er);
    n_total++;
    assert (ret_w === er_w) n_pass++;
    else $error("FAIL %s retired3 got %0d exp %0d",
                tag, ret_w, er_w);
    n_total++;
    assert (!(mr && mw)) n_pass++;
    else $error("FAIL %s rd/wr overlap got %b%b exp not 11",
                tag, mr, mw);
  endtask

  task automatic step(
    input string tag, input logic r, input logic [15:0] in,
    input logic rdy, input logic z, input out_t e,
    input int er);
    rst = r;
    instr = in;
    mem_ready = rdy;
    zero = z;
    q_out.push_back(e);
    q_ret.push_back(er);
    #1;
    chk(tag);
    @(negedge clk);
  endtask

  function automatic out_t fetch(input logic [3:0] o,
                                 input logic rdy);
    fetch = mk(2'b00, o, rdy, rdy, 1'b1, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 2'b00, 1'b0);
  endfunction

  function automatic out_t quiet(input logic [3:0] o);
    quiet = mk(2'b00, o, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 2'b00, 1'b0);
  endfunction

  function automatic out_t brx(input logic [3:0] o,
                               input logic t);
    brx = mk(2'b01, o, 1'b0, t, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b0, 1'b0, 2'b01, 1'b0);
  endfunction

  initial begin
    step("reset", 1'b1, 16'h2345, 1'b1, 1'b1,
         quiet(4'h0), 0);
    step("idle", 1'b0, 16'h2345, 1'b1, 1'b1,
         quiet(4'h0), 0);
    // ADD
    step("add_f", 1'b0, 16'h2345, 1'b1, 1'b0,
         fetch(4'h0, 1'b1), 0);
    step("add_d", 1'b0, 16'hF000, 1'b0, 1'b1,
         quiet(4'h2), 0);
    step("add_e", 1'b0, 16'hF000, 1'b1, 1'b1,
         quiet(4'h2), 0);
    step("add_wb", 1'b0, 16'hF000, 1'b1, 1'b1,
         mk(2'b00, 4'h2, 0, 0, 0, 0, 1, 0, 0, 1, 2'b00, 0), 0);
    // LD with two wait cycles in MEM
    step("ld_f", 1'b0, 16'h0123, 1'b1, 1'b0,
         fetch(4'h2, 1'b1), 1);
    step("ld_d", 1'b0, 16'hE000, 1'b1, 1'b0,
         quiet(4'h0), 1);
    step("ld_e", 1'b0, 16'hE000, 1'b0, 1'b1,
         mk(2'b10, 4'h0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0), 1);
    for (int i = 0; i < 2; i++)
      step("ld_mwait", 1'b0, 16'hE000, 1'b0, 1'b1,
           mk(2'b00, 4'h0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0), 1);
    step("ld_m", 1'b0, 16'hE000, 1'b1, 1'b1,
         mk(2'b00, 4'h0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0), 1);
    step("ld_wb", 1'b0, 16'hE000, 1'b0, 1'b0,
         mk(2'b00, 4'h0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 0), 1);
    // BEQ taken / not taken
    step("beq1_f", 1'b0, 16'hB000, 1'b1, 1'b0,
         fetch(4'h0, 1'b1), 2);
    step("beq1_d", 1'b0, 16'h0000, 1'b1, 1'b1,
         quiet(4'hB), 2);
    step("beq1_e", 1'b0, 16'h0000, 1'b1, 1'b1,
         brx(4'hB, 1'b1), 2);
    step("beq0_f", 1'b0, 16'hB000, 1'b1, 1'b1,
         fetch(4'hB, 1'b1), 3);
    step("beq0_d", 1'b0, 16'h0000, 1'b0, 1'b0,
         quiet(4'hB), 3);
    step("beq0_e", 1'b0, 16'h0000, 1'b1, 1'b0,
         brx(4'hB, 1'b0), 3);
    // BNE, with a fetch wait first
    step("bne_fw", 1'b0, 16'hC000, 1'b0, 1'b1,
         fetch(4'hB, 1'b0), 4);
    step("bne1_f", 1'b0, 16'hC000, 1'b1, 1'b1,
         fetch(4'hB, 1'b1), 4);
    step("bne1_d", 1'b0, 16'h0000, 1'b1, 1'b1,
         quiet(4'hC), 4);
    step("bne1_e", 1'b0, 16'h0000, 1'b1, 1'b1,
         brx(4'hC, 1'b0), 4);
    step("bne0_f", 1'b0, 16'hC000, 1'b1, 1'b0,
         fetch(4'hC, 1'b1), 5);
    step("bne0_d", 1'b0, 16'h0000, 1'b1, 1'b1,
         quiet(4'hC), 5);
    step("bne0_e", 1'b0, 16'h0000, 1'b1, 1'b0,
         brx(4'hC, 1'b1), 5);
    // Illegal opcode
    step("ill_f", 1'b0, 16'hE000, 1'b1, 1'b0,
         fetch(4'hC, 1'b1), 6);
    step("ill_d", 1'b0, 16'h0000, 1'b1, 1'b1,
         mk(2'b00, 4'hE, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1), 6);
    // JMP
    step("jmp_f", 1'b0, 16'hD000, 1'b1, 1'b0,
         fetch(4'hE, 1'b1), 6);
    step("jmp_d", 1'b0, 16'h0000, 1'b1, 1'b0,
         mk(2'b00, 4'hD, 0, 1, 0, 0, 0, 0, 0, 0, 2'b10, 0), 6);
    // ST aborted by reset during MEM wait
    step("st_f", 1'b0, 16'h1000, 1'b1, 1'b0,
         fetch(4'hD, 1'b1), 7);
    step("st_d", 1'b0, 16'h0000, 1'b1, 1'b0,
         quiet(4'h1), 7);
    step("st_e", 1'b0, 16'h0000, 1'b1, 1'b0,
         mk(2'b10, 4'h1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0), 7);
    step("st_mwait", 1'b0, 16'h0000, 1'b0, 1'b0,
         mk(2'b00, 4'h1, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0), 7);
    #2;
    step("st_rst", 1'b1, 16'h0000, 1'b0, 1'b0,
         quiet(4'h0), 0);
    step("rel_idle", 1'b0, 16'h1000, 1'b1, 1'b0,
         quiet(4'h0), 0);
    step("rel_f", 1'b0, 16'h1000, 1'b1, 1'b0,
         fetch(4'h0, 1'b1), 0);
    step("st2_d", 1'b0, 16'h0000, 1'b1, 1'b0,
         quiet(4'h1), 0);
    step("st2_e", 1'b0, 16'h0000, 1'b1, 1'b0,
         mk(2'b10, 4'h1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0), 0);
    step("st2_m", 1'b0, 16'h0000, 1'b1, 1'b0,
         mk(2'b00, 4'h1, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0), 0);
    // JMP stream drives the 3-bit counter through its wrap
    for (int i = 0; i < 8; i++) begin
      step("wrap_f", 1'b0, 16'hD000, 1'b1, 1'b0,
           fetch(i == 0 ? 4'h1 : 4'hD, 1'b1), 1 + i);
      step("wrap_d", 1'b0, 16'h0000, 1'b1, 1'b0,
           mk(2'b00, 4'hD, 0, 1, 0, 0, 0, 0, 0, 0, 2'b10, 0),
           1 + i);
    end
    step("wrap_end", 1'b0, 16'h0000, 1'b0, 1'b0,
         fetch(4'hD, 1'b0), 9);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter RETIRE_W, default 16, width of the retired-instruction counter.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 instr  input  16  instruction word from instruction memory; opcode = instr[15:12].
REQ-005 mem_ready  input  1  memory handshake; access completes on an edge where mem_ready=1.
REQ-006 zero  input  1  ALU zero flag, sampled in EXEC only.
REQ-007 ALUOp  output  2  ALU class to the downstream ALU control stage.
REQ-008 Opcode  output  4  latched opcode to the downstream ALU control stage.
REQ-009 ir_load, pc_write, mem_read, mem_write, reg_write, mem_to_reg, alu_src, reg_dst  output  1 each  datapath strobes/selects.
REQ-010 pc_src  output  2  00 = PC+2, 01 = branch target, 10 = jump target.
REQ-011 illegal  output  1  one-cycle pulse on an undefined opcode.
REQ-012 retired  output  RETIRE_W  count of completed instructions.

Function
REQ-013 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC, MEM, WB; outputs are Moore-decoded from state and the latched opcode, and every strobe not listed for a state is 0.
REQ-014 Opcode map: 0000 LD, 0001 ST, 0010-1001 R-type, 1011 BEQ, 1100 BNE, 1101 JMP; 1010, 1110, 1111 are illegal.
REQ-015 IDLE: all outputs 0; go to FETCH on the next edge.
REQ-016 FETCH: mem_read=1; stay while mem_ready=0.
  - When mem_ready=1: ir_load=1, pc_write=1, pc_src=00.
  - At that edge Opcode <= instr[15:12]; go to DECODE.
REQ-017 DECODE (exactly 1 cycle):
  - JMP: pc_write=1, pc_src=10, retired+1, go to FETCH.
  - Illegal: illegal=1, retired unchanged, go to FETCH.
  - Otherwise: go to EXEC.
REQ-018 EXEC, ALUOp by class:
  - LD/ST: ALUOp=10, alu_src=1, go to MEM.
  - R-type: ALUOp=00, alu_src=0, go to WB.
  - BEQ/BNE: ALUOp=01, go to FETCH, retired+1.
  - ALUOp SHALL be 00 in every state other than EXEC.
REQ-019 Branch: in EXEC, pc_src=01 and pc_write=(zero) for BEQ or (~zero) for BNE.
REQ-020 MEM, held while mem_ready=0:
  - LD: mem_read=1; on mem_ready=1 go to WB.
  - ST: mem_write=1; on mem_ready=1 go to FETCH and retired+1.
REQ-021 WB (1 cycle): reg_write=1.
  - LD: mem_to_reg=1, reg_dst=0.
  - R-type: mem_to_reg=0, reg_dst=1.
  - Then go to FETCH, retired+1.
REQ-022 Opcode SHALL change only at the FETCH completion edge and stay stable through DECODE/EXEC/MEM/WB.
REQ-023 Cycle counts with zero-wait memory: R-type 4, LD 5, ST 4, BEQ/BNE 3, JMP 2, illegal 2.
  - Each wait cycle (mem_ready=0 in FETCH/MEM) adds one cycle.
REQ-024 retired SHALL wrap from all-ones to 0 without saturation.
REQ-025 mem_read and mem_write SHALL never be 1 in the same cycle.
REQ-026 zero and mem_ready SHALL be ignored in states where they are not specified above.

Reset
REQ-027 While rst=1, the FSM SHALL be in IDLE, Opcode=0000, retired=0, and all other outputs 0, asynchronously.
REQ-028 Reset asserted mid-instruction (including during a MEM wait) SHALL abort it.
  - No further strobes are driven.
  - retired is not incremented.
  - After release the FSM passes IDLE then FETCH.

Verification
REQ-029 ADD (instr=16'h2xxx), mem_ready=1 -> states IDLE, FETCH, DECODE, EXEC, WB, FETCH.
  - ALUOp=00 and Opcode=0010 in EXEC.
  - reg_write=1, reg_dst=1 in WB.
  - retired 0 -> 1.
REQ-030 LD (16'h0xxx) with mem_ready=0 for 2 cycles in MEM:
  - ALUOp=10, alu_src=1 in EXEC.
  - mem_read held for 3 cycles in MEM.
  - WB has mem_to_reg=1.
  - Total 7 cycles.
REQ-031 BEQ (16'hBxxx):
  - zero=1: pc_write=1, pc_src=01 in EXEC.
  - zero=0: pc_write=0 in EXEC.
  - BNE (16'hCxxx) gives the inverse.
  - ALUOp=01 in EXEC in all cases.
REQ-032 Opcode 1110 -> illegal=1 for one cycle in DECODE, no reg_write/mem_write, retired unchanged, next state FETCH.
REQ-033 Assert rst during ST MEM wait -> mem_write drops to 0 immediately, Opcode=0000, retired unchanged; after release the first ir_load occurs 2 cycles later with mem_ready=1.
REQ-034 Preload retired to 16'hFFFF via 65535 JMPs (or a force) plus one more JMP -> retired=0.
